inst_decode: RTL and testbench
==============================

# inst_decode

Instruction decode stage between the fetch logic in `cpu_top` and the execute stage. It accepts one fetched RV32I instruction word and its PC per valid/ready handshake, and reads both source operands from the register file through a combinational read port. It then registers a fully decoded bundle (class, register indices, operand values, immediate, illegal flag) for the execute stage. A one-entry skid buffer lets `in_ready` be a registered signal, so execute back-pressure never forms a combinational path into fetch.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `aclk` input 1: clock; all state updates on the rising edge.
- `aresetn` input 1: reset; asynchronous, active-low.
- `flush` input 1: discard all held and incoming instructions (branch redirect).
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage can accept; equals NOT skid_valid.
- `in_inst` input 32: instruction word.
- `in_pc` input 32: PC of `in_inst`.
- `rs1_addr`, `rs2_addr` output 5: register-file read addresses, combinational from `in_inst[19:15]` and `in_inst[24:20]`.
- `rs1_data`, `rs2_data` input 32: register-file read data, same cycle.
- `out_valid` output 1: decoded bundle valid.
- `out_ready` input 1: execute accepts the bundle.
- `out_pc` output 32, `out_class` output 4, `out_funct3` output 3, `out_funct7b5` output 1, `out_rd` output 5, `out_rd_we` output 1, `out_rs1_val` output 32, `out_rs2_val` output 32, `out_imm` output 32, `out_illegal` output 1.

## Operation
- Decode happens combinationally on `in_inst`. A transfer in occurs when `in_valid` and `in_ready` are both 1 at a rising edge.
- Output register (main) plus one skid entry. Each entry holds a valid bit and the full bundle, including operand values sampled at the accept edge.
- On an edge with a transfer in:
  - If main is empty, or main is drained this edge (`out_ready` = 1), the bundle goes to main.
  - Otherwise it goes to skid.
- When main drains and skid is valid, skid moves to main and skid clears. Ordering is strictly FIFO.
- A transfer in while skid is valid cannot occur, because `in_ready` is 0.
- Classes and opcodes:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
  - BRANCH 1100011, LOAD 0000011, STORE 0100011
  - OP_IMM 0010011, OP 0110011, FENCE 0001111, SYSTEM 1110011
  - Any other value is ILLEGAL (class code 0).
- `out_illegal` = 1 for any of:
  - `inst[1:0]` not equal to 11, or an unknown opcode
  - JALR with funct3 not 000
  - BRANCH with funct3 010 or 011
  - LOAD with funct3 011, 110 or 111
  - STORE with funct3 greater than 010
  - OP with funct7 not 0000000, except 0100000 with funct3 000 or 101
  - OP_IMM shift (funct3 001 or 101) with an illegal funct7 under the same rule
- Illegal instructions are still emitted with `out_rd_we` = 0.
- `out_rd_we` = 1 only for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM and OP, and only when rd is not 0.
- Immediates are formed from the standard RV32I I, S, B, U and J formats. All are sign-extended from `inst[31]`; U is `inst[31:12]` followed by 12 zeros. `out_imm` = 0 for OP, FENCE, SYSTEM and ILLEGAL.
- `out_funct7b5` = `inst[30]`.
- Read-after-write hazards against in-flight writes are the responsibility of the issue/forwarding logic, not this block.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N has `out_valid` = 1 after edge N.
- Throughput is one instruction per cycle while `out_ready` = 1.
- `in_ready` is registered and depends only on skid_valid.
- Reset (asynchronous, while `aresetn` = 0):
  - main_valid and skid_valid = 0, so `out_valid` = 0 and `in_ready` = 1
  - all `out_*` fields = 0
- Reset asserted mid-operation drops both entries immediately, with no partial bundle remaining.
- Flush: at the edge where `flush` = 1, both entries clear and any simultaneous transfer in is dropped. The next cycle has `out_valid` = 0 and `in_ready` = 1. Flush has priority over drain and accept.
- Once `out_valid` is 1, the `out_*` fields remain stable until the cycle after an edge with `out_ready` = 1.

## Structure
- Package `cpu_pkg` contains:
  - `inst_class_e` enum (4-bit) and the opcode localparams
  - the `decoded_t` packed struct (pc, class, funct3, funct7b5, rd, rd_we, rs1_val, rs2_val, imm, illegal), shared with execute
- Sub-module `imm_gen`: purely combinational, instruction word to 32-bit immediate by class.
- The skid/handshake logic stays in `inst_decode`.

## Test plan
- Reset then `0x00500093` (addi x1,x0,5) with `rs1_data` = 0 -> one cycle later `out_valid` = 1, class OP_IMM, `out_rd` = 1, `out_rd_we` = 1, `out_imm` = 0x00000005.
- `0x123452B7` (lui x5,0x12345) -> `out_imm` = 0x12345000, `out_rd` = 5.
- `0xFE000EE3` (beq x0,x0,-4) -> class BRANCH, `out_imm` = 0xFFFFFFFC, `out_rd_we` = 0.
- `0x00000000` -> `out_illegal` = 1, class ILLEGAL, `out_rd_we` = 0.
- Back-pressure: `out_ready` = 0 while pushing PCs 0x0, 0x4, 0x8.
  - After the second accept, `in_ready` = 0 and the third instruction is held by fetch.
  - Then raise `out_ready` -> outputs appear in order 0x0, 0x4, 0x8 with no loss or duplication.
- Flush with both entries full and `in_valid` = 1 -> the next cycle has `out_valid` = 0 and `in_ready` = 1, and the dropped instruction never appears. Repeat with `aresetn` pulsed low mid-stream -> the same empty state is reached immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared RV32I decode types. Holds the instruction-class enum,
//                the major-opcode constants, the decoded bundle handed from
//                decode to execute, and an opcode-to-class lookup helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Class code 0 is reserved for anything that is not a known major opcode.
  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_LUI     = 4'd1,
    CLS_AUIPC   = 4'd2,
    CLS_JAL     = 4'd3,
    CLS_JALR    = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_LOAD    = 4'd6,
    CLS_STORE   = 4'd7,
    CLS_OP_IMM  = 4'd8,
    CLS_OP      = 4'd9,
    CLS_FENCE   = 4'd10,
    CLS_SYSTEM  = 4'd11
  } inst_class_e;

  // RV32I major opcodes (inst[6:0]).
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct7 value that selects SUB / SRA / SRAI.
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  // Decoded bundle shared with the execute stage.
  typedef struct packed {
    logic [31:0] pc;
    inst_class_e cls;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        illegal;
  } decoded_t;

  // Map a major opcode onto its instruction class. Because every listed
  // opcode ends in 2'b11, a word with inst[1:0] != 2'b11 falls to ILLEGAL.
  function automatic inst_class_e opcode_to_class(input logic [6:0] opcode);
    inst_class_e cls;
    case (opcode)
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_OP:     cls = CLS_OP;
      OPC_FENCE:  cls = CLS_FENCE;
      OPC_SYSTEM: cls = CLS_SYSTEM;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Purely combinational RV32I immediate generator. Selects the
//                I, S, B, U or J format from the instruction class and
//                sign-extends from inst[31]. Classes without an immediate
//                (OP, FENCE, SYSTEM, ILLEGAL) produce zero.
//  Ports       : inst  - instruction bits [31:7] (opcode not needed here)
//                cls   - decoded instruction class
//                imm   - 32-bit immediate
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
  import cpu_pkg::*;
(
  input  logic [31:7]  inst,
  input  inst_class_e  cls,
  output logic [31:0]  imm
);

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  // All five candidate formats are built in parallel; the class picks one.
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    imm = '0;
    case (cls)
      CLS_JALR,
      CLS_LOAD,
      CLS_OP_IMM: imm = imm_i;
      CLS_STORE:  imm = imm_s;
      CLS_BRANCH: imm = imm_b;
      CLS_LUI,
      CLS_AUIPC:  imm = imm_u;
      CLS_JAL:    imm = imm_j;
      default:    imm = '0;
    endcase
  end

endmodule : imm_gen
`default_nettype wire

// File: rtl/inst_decode.sv
`default_nettype none
// ============================================================================
//  Module      : inst_decode
//  Description : RV32I decode stage. Accepts one instruction + PC per
//                valid/ready handshake, reads both source operands through a
//                combinational register-file port, and registers a fully
//                decoded bundle for execute. A one-entry skid buffer behind
//                the output register lets in_ready come straight from a flop,
//                so execute back-pressure never reaches fetch combinationally.
//  Ports       : aclk, aresetn          - clock, async active-low reset
//                flush                  - drop held and incoming instructions
//                in_valid/in_ready      - fetch handshake
//                in_inst, in_pc         - instruction word and its PC
//                rs1_addr, rs2_addr     - register-file read addresses
//                rs1_data, rs2_data     - register-file read data (same cycle)
//                out_valid/out_ready    - execute handshake
//                out_*                  - decoded bundle fields
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_decode
  import cpu_pkg::*;
#(
  parameter int XLEN = 32   // only 32 is supported
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_class,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  // --------------------------------------------------------------------------
  // Field extraction and combinational decode of the incoming word
  // --------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  inst_class_e cls;
  logic        funct7_ok;
  logic        is_shift_imm;
  logic        illegal;
  logic        writes_rd;
  logic [31:0] imm;
  decoded_t    bundle;

  assign opcode   = in_inst[6:0];
  assign rd       = in_inst[11:7];
  assign funct3   = in_inst[14:12];
  assign funct7   = in_inst[31:25];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  assign cls = opcode_to_class(opcode);

  // funct7 must be zero, except the alternate encoding that selects SUB
  // (funct3 000) or SRA/SRAI (funct3 101). Shared by OP and OP_IMM shifts.
  assign funct7_ok    = (funct7 == 7'b0000000) ||
                        ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  assign is_shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    illegal   = 1'b0;
    writes_rd = 1'b0;
    case (cls)
      CLS_ILLEGAL: illegal = 1'b1;
      CLS_LUI,
      CLS_AUIPC,
      CLS_JAL:     writes_rd = 1'b1;
      CLS_JALR: begin
        writes_rd = 1'b1;
        illegal   = (funct3 != 3'b000);
      end
      CLS_BRANCH:  illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      CLS_LOAD: begin
        writes_rd = 1'b1;
        illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      CLS_STORE:   illegal = (funct3 > 3'b010);
      CLS_OP_IMM: begin
        writes_rd = 1'b1;
        illegal   = is_shift_imm && !funct7_ok;
      end
      CLS_OP: begin
        writes_rd = 1'b1;
        illegal   = !funct7_ok;
      end
      default: begin
        illegal   = 1'b0;
        writes_rd = 1'b0;
      end
    endcase
  end

  imm_gen u_imm_gen (
    .inst (in_inst[31:7]),
    .cls  (cls),
    .imm  (imm)
  );

  // Bundle as it would be captured at this edge. Operand values are sampled
  // now; later register-file updates are not visible to this instruction.
  always_comb begin
    bundle          = '0;
    bundle.pc       = in_pc;
    bundle.cls      = cls;
    bundle.funct3   = funct3;
    bundle.funct7b5 = in_inst[30];
    bundle.rd       = rd;
    // Illegal words still flow to execute but must never write x0..x31.
    bundle.rd_we    = writes_rd && !illegal && (rd != 5'd0);
    bundle.rs1_val  = rs1_data;
    bundle.rs2_val  = rs2_data;
    bundle.imm      = imm;
    bundle.illegal  = illegal;
  end

  // --------------------------------------------------------------------------
  // Output register (main) + one skid entry, strict FIFO order
  // --------------------------------------------------------------------------
  decoded_t main_q;
  decoded_t main_d;
  logic     main_valid_q;
  logic     main_valid_d;
  decoded_t skid_q;
  decoded_t skid_d;
  logic     skid_valid_q;
  logic     skid_valid_d;

  logic     accept;
  logic     main_free;

  // in_ready is a pure flop output; it cannot depend on out_ready.
  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid && in_ready;
  // Main can take a new bundle if it is empty or is being drained this edge.
  assign main_free = !main_valid_q || out_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      // Redirect wins over drain and accept; bundle contents are don't-care.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Older skid entry goes first; accept is impossible (in_ready = 0).
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = bundle;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled; park the new bundle in the skid entry.
      skid_d       = bundle;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs straight from the main entry
  // --------------------------------------------------------------------------
  assign out_valid    = main_valid_q;
  assign out_pc       = main_q.pc;
  assign out_class    = main_q.cls;
  assign out_funct3   = main_q.funct3;
  assign out_funct7b5 = main_q.funct7b5;
  assign out_rd       = main_q.rd;
  assign out_rd_we    = main_q.rd_we;
  assign out_rs1_val  = main_q.rs1_val;
  assign out_rs2_val  = main_q.rs2_val;
  assign out_imm      = main_q.imm;
  assign out_illegal  = main_q.illegal;

endmodule : inst_decode
`default_nettype wire

// File: tb/tb_inst_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_decode
//  Description : Self-checking bench for inst_decode: a table of directed
//                instruction words, hand-written back-pressure / flush /
//                reset sequences, then randomized traffic checked against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_decode;
  import cpu_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [3:0]  out_class;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_rd_we, out_illegal;
  logic [4:0]  out_rd;

  logic [31:0] rf [32];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  inst_decode #(.XLEN(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_class(out_class),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit alu_f7_ok(input logic [6:0] f7, input logic [2:0] f3);
    return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
  endfunction

  function automatic decoded_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                          input logic [31:0] a, input logic [31:0] b);
    decoded_t d;
    int       s;
    logic [2:0] f3;
    logic [6:0] f7;
    byte      fmt;
    bit       wr;
    bit       bad;
    s   = int'(inst);
    f3  = inst[14:12];
    f7  = inst[31:25];
    d   = '0;
    d.pc = pc; d.funct3 = f3; d.funct7b5 = inst[30]; d.rd = inst[11:7];
    d.rs1_val = a; d.rs2_val = b;
    fmt = "-"; wr = 0; bad = 0;
    case (inst[6:0])
      7'h37: begin d.cls = CLS_LUI;    fmt = "U"; wr = 1; end
      7'h17: begin d.cls = CLS_AUIPC;  fmt = "U"; wr = 1; end
      7'h6F: begin d.cls = CLS_JAL;    fmt = "J"; wr = 1; end
      7'h67: begin d.cls = CLS_JALR;   fmt = "I"; wr = 1; bad = (f3 != 0); end
      7'h63: begin d.cls = CLS_BRANCH; fmt = "B"; bad = (f3 == 2 || f3 == 3); end
      7'h03: begin d.cls = CLS_LOAD;   fmt = "I"; wr = 1; bad = (f3 == 3 || f3 >= 6); end
      7'h23: begin d.cls = CLS_STORE;  fmt = "S"; bad = (f3 > 2); end
      7'h13: begin d.cls = CLS_OP_IMM; fmt = "I"; wr = 1;
                   bad = (f3 == 1 || f3 == 5) && !alu_f7_ok(f7, f3); end
      7'h33: begin d.cls = CLS_OP;     wr = 1; bad = !alu_f7_ok(f7, f3); end
      7'h0F: d.cls = CLS_FENCE;
      7'h73: d.cls = CLS_SYSTEM;
      default: begin d.cls = CLS_ILLEGAL; bad = 1; end
    endcase
    case (fmt)
      "I": d.imm = 32'(s >>> 20);
      "S": d.imm = 32'(((s >>> 25) <<< 5) | int'(inst[11:7]));
      "B": d.imm = 32'(((s >>> 31) <<< 12) | (int'(inst[7]) << 11)
                       | (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1));
      "U": d.imm = inst & 32'hFFFF_F000;
      "J": d.imm = 32'(((s >>> 31) <<< 20) | (int'(inst[19:12]) << 12)
                       | (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1));
      default: d.imm = 32'd0;
    endcase
    d.illegal = bad;
    d.rd_we   = wr && !bad && (d.rd != 5'd0);
    return d;
  endfunction

  decoded_t got;
  always_comb begin
    got          = '0;
    got.pc       = out_pc;
    got.cls      = inst_class_e'(out_class);
    got.funct3   = out_funct3;
    got.funct7b5 = out_funct7b5;
    got.rd       = out_rd;
    got.rd_we    = out_rd_we;
    got.rs1_val  = out_rs1_val;
    got.rs2_val  = out_rs2_val;
    got.imm      = out_imm;
    got.illegal  = out_illegal;
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  logic [31:0] addi_w = 32'h0050_0093;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    decoded_t q[$];
    decoded_t expb;
    logic [6:0] opcs [11];
    logic [31:0] tmp;
    bit acc, drn;

    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;

    vt[0]  = '{32'h0050_0093, CLS_OP_IMM, 5'd1,  1'b1, 32'h0000_0005, 1'b0};
    vt[1]  = '{32'h1234_52B7, CLS_LUI,    5'd5,  1'b1, 32'h1234_5000, 1'b0};
    vt[2]  = '{32'hFE00_0EE3, CLS_BRANCH, 5'd29, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vt[3]  = '{32'h0000_0000, CLS_ILLEGAL,5'd0,  1'b0, 32'h0000_0000, 1'b1};
    vt[4]  = '{32'h0000_1067, CLS_JALR,   5'd0,  1'b0, 32'h0000_0000, 1'b1};
    vt[5]  = '{32'h4000_00B3, CLS_OP,     5'd1,  1'b1, 32'h0000_0000, 1'b0};
    vt[6]  = '{32'h4000_10B3, CLS_OP,     5'd1,  1'b0, 32'h0000_0000, 1'b1};
    vt[7]  = '{32'h0010_9093, CLS_OP_IMM, 5'd1,  1'b1, 32'h0000_0001, 1'b0};
    vt[8]  = '{32'h4010_D093, CLS_OP_IMM, 5'd1,  1'b1, 32'h0000_0401, 1'b0};
    vt[9]  = '{32'h4010_9093, CLS_OP_IMM, 5'd1,  1'b0, 32'h0000_0401, 1'b1};
    vt[10] = '{32'h0000_3023, CLS_STORE,  5'd0,  1'b0, 32'h0000_0000, 1'b1};
    vt[11] = '{32'h0000_6083, CLS_LOAD,   5'd1,  1'b0, 32'h0000_0000, 1'b1};
    vt[12] = '{32'h0000_2063, CLS_BRANCH, 5'd0,  1'b0, 32'h0000_0000, 1'b1};
    vt[13] = '{32'h0050_0092, CLS_ILLEGAL,5'd1,  1'b0, 32'h0000_0000, 1'b1};
    vt[14] = '{32'h0080_00EF, CLS_JAL,    5'd1,  1'b1, 32'h0000_0008, 1'b0};
    vt[15] = '{32'hFE11_2E23, CLS_STORE,  5'd28, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vt[16] = '{32'h0000_1217, CLS_AUIPC,  5'd4,  1'b1, 32'h0000_1000, 1'b0};
    vt[17] = '{32'h0000_0073, CLS_SYSTEM, 5'd0,  1'b0, 32'h0000_0000, 1'b0};
    vt[18] = '{32'h0FF0_000F, CLS_FENCE,  5'd0,  1'b0, 32'h0000_0000, 1'b0};

    // ---------------- reset state ----------------
    #2 aresetn = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_pc",    out_pc,  32'd0);
    chk("rst_out_imm",   out_imm, 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_out_rs1",   out_rs1_val, 32'd0);
    chk("rst_out_misc",  32'({out_funct3, out_funct7b5, out_rd, out_rd_we, out_illegal}), 32'd0);
    aresetn = 1'b1;
    tick();

    // ---------------- directed table, 1-cycle latency ----------------
    for (int i = 0; i < NV; i++) begin
      in_valid  = 1'b1;
      in_inst   = vt[i].inst;
      in_pc     = 32'h1000 + 32'(4 * i);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_pc", i), out_pc, 32'h1000 + 32'(4 * i));
      chk($sformatf("vec%0d_class", i), 32'(out_class), 32'(vt[i].cls));
      chk($sformatf("vec%0d_rd", i), 32'(out_rd), 32'(vt[i].rd));
      chk($sformatf("vec%0d_rd_we", i), 32'(out_rd_we), 32'(vt[i].rd_we));
      chk($sformatf("vec%0d_imm", i), out_imm, vt[i].imm);
      chk($sformatf("vec%0d_illegal", i), 32'(out_illegal), 32'(vt[i].ill));
      chk($sformatf("vec%0d_rs1", i), out_rs1_val, rf[vt[i].inst[19:15]]);
      chk($sformatf("vec%0d_rs2", i), out_rs2_val, rf[vt[i].inst[24:20]]);
    end
    tick();
    chk("table_drained", 32'(out_valid), 32'd0);

    // ---------------- back-pressure ordering ----------------
    out_ready = 1'b0; in_valid = 1'b1; in_inst = addi_w; in_pc = 32'h0;
    tick();
    chk("bp_a_valid", 32'(out_valid), 32'd1);
    chk("bp_a_ready", 32'(in_ready), 32'd1);
    chk("bp_a_pc", out_pc, 32'h0);
    in_pc = 32'h4;
    tick();
    chk("bp_b_in_ready", 32'(in_ready), 32'd0);
    chk("bp_b_pc", out_pc, 32'h0);
    in_pc = 32'h8;
    tick();
    chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("bp_1_pc", out_pc, 32'h4);
    chk("bp_1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_2_pc", out_pc, 32'h8);
    chk("bp_2_valid", 32'(out_valid), 32'd1);
    tick();
    chk("bp_end_valid", 32'(out_valid), 32'd0);

    // ---------------- flush with both entries full ----------------
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h100;
    tick();
    in_pc = 32'h104;
    tick();
    chk("fl_full_in_ready", 32'(in_ready), 32'd0);
    in_pc = 32'h108; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fl_empty%0d", k), 32'(out_valid), 32'd0);
    end

    // ---------------- flush drops a simultaneous accept ----------------
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200;
    tick();
    in_pc = 32'h204; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fla_out_valid", 32'(out_valid), 32'd0);
    chk("fla_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("fla_dropped", 32'(out_valid), 32'd0);

    // ---------------- asynchronous reset mid-stream ----------------
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300;
    tick();
    in_pc = 32'h304;
    tick();
    in_valid = 1'b0;
    #1 aresetn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_pc", out_pc, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    chk("arst_after_valid", 32'(out_valid), 32'd0);

    // ---------------- randomized traffic vs queue model ----------------
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      tmp = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        in_inst = tmp;
      end else begin
        if ($urandom_range(0, 1) == 1) tmp[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        in_inst = {tmp[31:7], opcs[$urandom_range(0, 10)]};
      end
      in_pc     = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);

      @(negedge aclk);
      chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        checks++;
        if (got !== q[0]) begin
          failures++;
          $display("FAIL rnd_bundle: got %h expected %h", got, q[0]);
        end
      end
      acc  = in_valid && (q.size() < 2);
      drn  = (q.size() > 0) && out_ready;
      expb = ref_decode(in_inst, in_pc, rf[in_inst[19:15]], rf[in_inst[24:20]]);

      @(posedge aclk);
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(expb);
      end
      #1;
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_inst_decode
`default_nettype wire
